// File: rtl/stack_pop_assembler.sv
// -----------------------------------------------------------------------------
// stack_pop_assembler
//
// Pops a return context from the stack as a series of narrow memory beats.
// The beats are assembled into a wide PC, followed by an optional flags word
// for RTI. Both are committed together, so a half-built PC is never visible.
// The stack-pointer increment strobe is driven once for every accepted beat.
//
// Configuration macro:
//   STACK_POP_FLAGS_EN  defined   -> RTI support (with_flags_i selects a
//                                    trailing flags beat).
//                       undefined -> with_flags_i is ignored, every sequence
//                                    is RET-length, flags_out_o and
//                                    flag_sel_o are tied to 0.
//
// Parameters:
//   DATA_W  width of one memory beat
//   BEATS   beats per PC (1..8); PC width is DATA_W*BEATS
//   FLAG_W  flags width, taken from the low bits of the flags beat (<= DATA_W)
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   start_i       one-cycle request to begin a pop sequence (honoured in IDLE only)
//   with_flags_i  sampled with start_i: 1 = RTI, 0 = RET
//   flush_i       synchronous abort; returns to IDLE without a commit
//   mem_rd_o      beat request to data memory
//   mem_valid_i   beat data valid for the current request
//   mem_data_i    beat data
//   sp_inc_o      stack-pointer increment (mem_rd_o & mem_valid_i)
//   busy_o        high in every state except IDLE
//   pc_out_o      last committed PC
//   flags_out_o   last committed flags
//   flag_sel_o    pulses with done_o when flags_out_o was updated
//   done_o        one-cycle commit pulse
// -----------------------------------------------------------------------------
module stack_pop_assembler #(
  parameter int DATA_W = 16,
  parameter int BEATS  = 2,
  parameter int FLAG_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    with_flags_i,
  input  logic                    flush_i,
  output logic                    mem_rd_o,
  input  logic                    mem_valid_i,
  input  logic [DATA_W-1:0]       mem_data_i,
  output logic                    sp_inc_o,
  output logic                    busy_o,
  output logic [DATA_W*BEATS-1:0] pc_out_o,
  output logic [FLAG_W-1:0]       flags_out_o,
  output logic                    flag_sel_o,
  output logic                    done_o
);

  localparam int PC_W  = DATA_W * BEATS;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_POP_PC    = 2'd1;
  localparam logic [1:0] S_POP_FLAGS = 2'd2;
  localparam logic [1:0] S_COMMIT    = 2'd3;

  logic [1:0]       state_q,      state_d;
  logic [CNT_W-1:0] beat_cnt_q,   beat_cnt_d;
  logic [PC_W-1:0]  shadow_q,     shadow_d;
  logic             with_flags_q, with_flags_d;
  logic [PC_W-1:0]  pc_q,         pc_d;
  logic             done_q,       done_d;

  logic             accept;
  logic             last_beat;
  logic             rti_req;
  logic [PC_W-1:0]  shadow_merged;

  // ---------------------------------------------------------------------------
  // Memory handshake. sp_inc is combinational so a beat presented in the same
  // cycle as flush still moves the stack pointer.
  // ---------------------------------------------------------------------------
  assign mem_rd_o  = (state_q == S_POP_PC) || (state_q == S_POP_FLAGS);
  assign accept    = mem_rd_o && mem_valid_i;
  assign sp_inc_o  = accept;
  assign busy_o    = (state_q != S_IDLE);
  assign last_beat = (beat_cnt_q == LAST_BEAT);

  // Shadow value with the beat currently on the bus dropped into its slot.
  // Beat k lands at bits [k*DATA_W +: DATA_W], so the first popped beat is the
  // least significant. Using this merged value lets the final PC beat commit
  // on the same edge that accepts it.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
      assign shadow_merged[gi*DATA_W +: DATA_W] =
        (beat_cnt_q == CNT_W'(gi)) ? mem_data_i : shadow_q[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Optional RTI flags path.
  // ---------------------------------------------------------------------------
`ifdef STACK_POP_FLAGS_EN
  logic [FLAG_W-1:0] flags_q;
  logic              flag_sel_q;
  logic              flags_commit;

  assign rti_req = with_flags_i;

  // The flags beat is the last beat of an RTI, so its data is committed
  // straight into flags_q on the edge that enters COMMIT. No separate shadow
  // copy is needed to keep the PC/flags update atomic.
  assign flags_commit = (state_q == S_POP_FLAGS) && accept && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= '0;
      flag_sel_q <= 1'b0;
    end else begin
      flag_sel_q <= flags_commit;
      if (flags_commit) begin
        flags_q <= mem_data_i[FLAG_W-1:0];
      end
    end
  end

  assign flags_out_o = flags_q;
  assign flag_sel_o  = flag_sel_q;
`else
  logic unused_with_flags;

  assign rti_req           = 1'b0;
  assign unused_with_flags = with_flags_i;
  assign flags_out_o       = '0;
  assign flag_sel_o        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    shadow_d     = shadow_q;
    with_flags_d = with_flags_q;
    pc_d         = pc_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          with_flags_d = rti_req;
          beat_cnt_d   = '0;
          state_d      = S_POP_PC;
        end
      end

      S_POP_PC: begin
        if (accept) begin
          shadow_d = shadow_merged;
          if (last_beat) begin
            if (with_flags_q) begin
              state_d = S_POP_FLAGS;
            end else begin
              pc_d    = shadow_merged;
              done_d  = 1'b1;
              state_d = S_COMMIT;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end

      S_POP_FLAGS: begin
        if (accept) begin
          pc_d    = shadow_q;
          done_d  = 1'b1;
          state_d = S_COMMIT;
        end
      end

      S_COMMIT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a start in the same cycle: no
    // commit, committed outputs keep their values, partial shadow dropped.
    if (flush_i) begin
      state_d    = S_IDLE;
      pc_d       = pc_q;
      done_d     = 1'b0;
      shadow_d   = shadow_q;
      beat_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      beat_cnt_q   <= '0;
      shadow_q     <= '0;
      with_flags_q <= 1'b0;
      pc_q         <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      shadow_q     <= shadow_d;
      with_flags_q <= with_flags_d;
      pc_q         <= pc_d;
      done_q       <= done_d;
    end
  end

  assign pc_out_o = pc_q;
  assign done_o   = done_q;

endmodule

// File: doc/stack_pop_assembler.md
# stack_pop_assembler

Parametrised successor to the fetch-stage PC/flags accumulator. Pops a return context from the stack as a sequence of narrow memory beats, assembles them into a wide PC and, for RTI, a flags word, and commits both atomically. Sits between the control state machine, which issues RET/RTI, and the data-memory read port. Also drives the stack-pointer increment strobe once per accepted beat.

## Interface
- DATA_W, 16, width of one memory beat
- BEATS, 2, beats per PC; PC width is DATA_W*BEATS; legal range 1..8
- FLAG_W, 3, flags width taken from the low bits of the flags beat; must satisfy FLAG_W <= DATA_W
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a pop sequence
- with_flags  in  1  sampled with start; 1 = RTI (PC beats then one flags beat), 0 = RET
- flush  in  1  synchronous abort of the current sequence
- mem_rd  out  1  beat request to data memory
- mem_valid  in  1  memory data valid for the current request
- mem_data  in  DATA_W  beat data
- sp_inc  out  1  stack-pointer increment; equals mem_rd & mem_valid
- busy  out  1  high in every state except IDLE
- pc_out  out  DATA_W*BEATS  last committed PC
- flags_out  out  FLAG_W  last committed flags
- flag_sel  out  1  one-cycle pulse together with done when flags_out was updated
- done  out  1  one-cycle commit pulse

## Operation
- States: IDLE, POP_PC, POP_FLAGS, COMMIT.
- IDLE: on start=1, latch with_flags, clear the beat counter, and go to POP_PC. A start while not in IDLE is ignored.
- POP_PC: mem_rd=1. A beat is accepted when mem_valid=1.
  - Beat k (k = 0..BEATS-1, in pop order) is written to shadow[k*DATA_W +: DATA_W], so the low beat comes first.
  - After accepting beat BEATS-1, go to POP_FLAGS if the latched with_flags is 1; otherwise go to COMMIT.
- POP_FLAGS: mem_rd=1. On mem_valid=1, latch mem_data[FLAG_W-1:0] into shadow_flags and go to COMMIT.
- COMMIT: copy the shadow register to pc_out, and shadow_flags to flags_out if with_flags=1. Pulse done, pulse flag_sel when flags were updated, then return to IDLE.
- pc_out and flags_out change only in COMMIT, so no partially assembled value is ever visible.
- mem_valid outside POP_PC and POP_FLAGS is ignored, and sp_inc stays 0.
- flush=1 in any state returns the FSM to IDLE on the next edge.
  - No commit takes place; pc_out and flags_out keep their previous values.
  - A beat presented in the same cycle as flush is still counted by sp_inc, because sp_inc is combinational. The shadow register is discarded.
  - flush takes priority over start in the same cycle.
- When BEATS=1, POP_PC lasts a single accept.

## Timing
- Reset values: state=IDLE, mem_rd=0, sp_inc=0, busy=0, done=0, flag_sel=0, pc_out=0, flags_out=0, beat counter=0, shadow registers=0.
- Reset asserted mid-sequence clears everything immediately; there is no pending commit.
- start sampled at edge 0 puts the FSM in POP_PC during cycle 1.
- With mem_valid held high:
  - RET: done is high in cycle BEATS+1.
  - RTI: done is high in cycle BEATS+2.
- Each memory wait cycle (mem_valid=0 while mem_rd=1) adds exactly one cycle.
- pc_out, flags_out, done and flag_sel are registered; they update on the edge that enters COMMIT.
- busy falls in the cycle after done. The next start is accepted in that same cycle, so back-to-back sequences have a 1-cycle gap.

## Configuration
- STACK_POP_FLAGS_EN defined: RTI support as described above.
- STACK_POP_FLAGS_EN undefined:
  - with_flags is ignored and POP_FLAGS is never entered.
  - flags_out is held at 0 and flag_sel is held at 0.
  - Every sequence is RET-length.

## Test plan
- RET, DATA_W=16, BEATS=2, mem_valid always 1, beats 0x1234 then 0xABCD -> pc_out=0xABCD1234 and done high in cycle 3; sp_inc high in cycles 1-2; flags_out unchanged.
- RTI with beats 0x0010, 0x0000, 0x0005 -> pc_out=0x00000010, flags_out=3'b101, flag_sel=done=1 in cycle 4; three sp_inc pulses.
- RET with mem_valid low for 2 cycles before the second beat -> done delayed to cycle 5, exactly 2 sp_inc pulses, and pc_out stays at its old value until commit.
- flush asserted after the first beat of a sequence -> FSM in IDLE next cycle, no done pulse, pc_out keeps its prior value; a following RET then completes normally.
- start asserted while busy, and mem_valid asserted in IDLE -> both ignored; sp_inc=0 in IDLE.
- rst_n pulled low during POP_FLAGS -> all outputs 0 at once; parameter sweep with BEATS=1 and BEATS=4 gives done in cycle BEATS+1.
